// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier: state encoding,
// operand width, iteration count and operand magnitude helper.
package mul_pkg;

  localparam int MUL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  // Number of RUN cycles needed to retire all multiplier bits.
  function automatic int iter_count(input int step);
    return MUL_W / step;
  endfunction

  // Two's-complement magnitude; the most negative value maps to 0x8000 exactly.
  function automatic logic [MUL_W-1:0] magnitude(input logic [MUL_W-1:0] v,
                                                 input logic             is_signed);
    return (is_signed && v[MUL_W-1]) ? (~v + MUL_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Operand/result handshake bundle between the CPU execute stage (master)
// and the multiply sequencer (slave).
interface mul_seq_ctrl_if;
  import mul_pkg::*;

  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid & ready are high and flush is low; valid holds its payload until then.
  logic             in_valid;
  logic             in_ready;
  logic [MUL_W-1:0] op_a;
  logic [MUL_W-1:0] op_b;
  logic             op_signed;
  logic             flush;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [MUL_W-1:0] prod_lo;
  logic [MUL_W-1:0] prod_hi;

  modport master (
    output in_valid, op_a, op_b, op_signed, flush, out_ready,
    input  in_ready, busy, out_valid, prod_lo, prod_hi
  );

  modport slave (
    input  in_valid, op_a, op_b, op_signed, flush, out_ready,
    output in_ready, busy, out_valid, prod_lo, prod_hi
  );

endinterface

// File: rtl/mul_step.sv
// One shift-and-add iteration: adds multiplicand x STEP multiplier bits into
// the upper accumulator half, then shifts {carry, acc} right by STEP.
module mul_step
  import mul_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [2*MUL_W-1:0] acc,
  input  logic [MUL_W-1:0]   mcand,
  input  logic [STEP-1:0]    bits,
  output logic [2*MUL_W-1:0] acc_next
);

  localparam int SUM_W = MUL_W + STEP;

  logic [SUM_W-1:0]         partial;
  logic [SUM_W-1:0]         sum;
  logic [2*MUL_W+STEP-1:0]  wide;

  // (2^16-1)*(2^STEP-1) + (2^16-1) < 2^(16+STEP), so SUM_W holds the carry.
  always_comb begin
    partial  = SUM_W'(mcand) * SUM_W'(bits);
    sum      = partial + SUM_W'(acc[2*MUL_W-1:MUL_W]);
    wide     = {sum, acc[MUL_W-1:0]};
    acc_next = wide[STEP +: 2*MUL_W];
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 16x16 multiply sequencer: magnitudes are multiplied STEP bits per
// cycle, and signed results are corrected in one fixed NEG cycle.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_seq_ctrl_if.slave bus,
  output mul_state_t    dbg_state
);

  localparam int N     = iter_count(STEP);
  localparam int CNT_W = 5;

  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
    $error("mul_seq_ctrl: STEP must be 1, 2, 4, 8 or 16");
  end

  mul_state_t         state;
  logic [MUL_W-1:0]   mcand_reg;
  logic [MUL_W-1:0]   mplier_reg;
  logic               signed_reg;
  logic               neg_flag;
  logic [2*MUL_W-1:0] acc;
  logic [2*MUL_W-1:0] acc_step;
  logic [2*MUL_W-1:0] acc_neg;
  logic [CNT_W-1:0]   count;
  logic [MUL_W-1:0]   prod_lo_reg;
  logic [MUL_W-1:0]   prod_hi_reg;
  logic               last_iter;

  mul_step #(.STEP(STEP)) u_step (
    .acc      (acc),
    .mcand    (mcand_reg),
    .bits     (mplier_reg[STEP-1:0]),
    .acc_next (acc_step)
  );

  assign acc_neg   = ~acc + (2*MUL_W)'(1);
  assign last_iter = (count == CNT_W'(N - 1));

  // Product outputs have their own registers so clearing acc on accept does
  // not disturb the result still visible from the previous multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      signed_reg  <= 1'b0;
      neg_flag    <= 1'b0;
      acc         <= '0;
      count       <= '0;
      prod_lo_reg <= '0;
      prod_hi_reg <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand_reg  <= magnitude(bus.op_a, bus.op_signed);
            mplier_reg <= magnitude(bus.op_b, bus.op_signed);
            signed_reg <= bus.op_signed;
            neg_flag   <= bus.op_signed & (bus.op_a[MUL_W-1] ^ bus.op_b[MUL_W-1]);
            acc        <= '0;
            count      <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc         <= acc_step;
          prod_hi_reg <= acc_step[2*MUL_W-1:MUL_W];
          prod_lo_reg <= acc_step[MUL_W-1:0];
          mplier_reg  <= mplier_reg >> STEP;
          count       <= count + CNT_W'(1);
          if (last_iter) begin
            state <= signed_reg ? NEG : DONE;
          end
        end
        NEG: begin
          // Taken for every signed multiply so latency does not depend on data.
          if (neg_flag) begin
            acc         <= acc_neg;
            prod_hi_reg <= acc_neg[2*MUL_W-1:MUL_W];
            prod_lo_reg <= acc_neg[MUL_W-1:0];
          end
          state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) & ~bus.flush;
  assign bus.busy      = (state == RUN) | (state == NEG);
  assign bus.out_valid = (state == DONE);
  assign bus.prod_lo   = prod_lo_reg;
  assign bus.prod_hi   = prod_hi_reg;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: three instances (STEP 1, 4, 16) checked against an
// arithmetic reference product and a latency rule derived from STEP.
module tb_mul_seq_ctrl;
  import mul_pkg::*;

  localparam int NDUT = 3;

  function automatic int step_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 16);
  endfunction

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NDUT-1:0] in_valid, op_signed, flush, out_ready;
  logic [15:0]     op_a [NDUT];
  logic [15:0]     op_b [NDUT];
  logic [NDUT-1:0] in_ready, busy, out_valid;
  logic [15:0]     prod_lo [NDUT];
  logic [15:0]     prod_hi [NDUT];
  mul_state_t      dbg_state [NDUT];

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    mul_seq_ctrl_if bus ();
    assign bus.in_valid  = in_valid[k];
    assign bus.op_a      = op_a[k];
    assign bus.op_b      = op_b[k];
    assign bus.op_signed = op_signed[k];
    assign bus.flush     = flush[k];
    assign bus.out_ready = out_ready[k];
    assign in_ready[k]   = bus.in_ready;
    assign busy[k]       = bus.busy;
    assign out_valid[k]  = bus.out_valid;
    assign prod_lo[k]    = bus.prod_lo;
    assign prod_hi[k]    = bus.prod_hi;

    mul_seq_ctrl #(.STEP(step_of(k))) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state[k])
    );
  end

  // reference model
  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  function automatic int ref_lat(input int k, input logic s);
    return 16 / step_of(k) + (s ? 1 : 0) + 1;
  endfunction

  function automatic logic [15:0] pick_operand();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h0000;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // driver tasks
  task automatic idle_inputs();
    in_valid  = '0;
    op_signed = '0;
    flush     = '0;
    out_ready = '0;
    for (int k = 0; k < NDUT; k++) begin
      op_a[k] = '0;
      op_b[k] = '0;
    end
  endtask

  // Issue one multiply on instance k with out_ready high and wait for the result.
  // lat counts cycles from the accept cycle to the first out_valid cycle.
  task automatic do_mul(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic s, output bit accepted, output int lat,
                        output logic [31:0] prod, output bit timed_out);
    @(negedge clk);
    op_a[k] = a;
    op_b[k] = b;
    op_signed[k] = s;
    in_valid[k] = 1'b1;
    out_ready[k] = 1'b1;
    #1 accepted = in_ready[k];
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) in_valid[k] = 1'b0;
    end while (!out_valid[k] && lat < 60);
    timed_out = !out_valid[k];
    prod = {prod_hi[k], prod_lo[k]};
  endtask

  // tests
  task automatic test_reset();
    for (int k = 0; k < NDUT; k++) begin
      total++; if (in_ready[k] !== 1'b1) begin bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, in_ready[k]); end
      total++; if (busy[k] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
      total++; if (out_valid[k] !== 1'b0) begin bad++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid[k]); end
      total++; if ({prod_hi[k], prod_lo[k]} !== 32'h0) begin bad++; $display("FAIL reset_prod[%0d]: got %h want 0", k, {prod_hi[k], prod_lo[k]}); end
      total++; if (dbg_state[k] !== IDLE) begin bad++; $display("FAIL reset_state[%0d]: got %0d want IDLE", k, dbg_state[k]); end
    end
  endtask

  task automatic test_unsigned_max();
    bit acc_ok, tmo; int lat; logic [31:0] p;
    do_mul(0, 16'hFFFF, 16'hFFFF, 1'b0, acc_ok, lat, p, tmo);
    total++; if (acc_ok !== 1'b1) begin bad++; $display("FAIL umax_accept: got %b want 1", acc_ok); end
    total++; if (tmo) begin bad++; $display("FAIL umax_timeout: got no out_valid want out_valid"); end
    total++; if (lat != 17) begin bad++; $display("FAIL umax_latency: got %0d want 17", lat); end
    total++; if (p !== 32'hFFFE_0001) begin bad++; $display("FAIL umax_prod: got %h want fffe0001", p); end
    do_mul(2, 16'hFFFF, 16'hFFFF, 1'b0, acc_ok, lat, p, tmo);
    total++; if (lat != 2) begin bad++; $display("FAIL umax_s16_latency: got %0d want 2", lat); end
    total++; if (p !== 32'hFFFE_0001) begin bad++; $display("FAIL umax_s16_prod: got %h want fffe0001", p); end
  endtask

  task automatic test_signed();
    logic [15:0] ta [3] = '{16'h8000, 16'hFFFF, 16'h0007};
    logic [15:0] tb [3] = '{16'h8000, 16'h0001, 16'hFFFD};
    logic [31:0] te [3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    bit acc_ok, tmo; int lat; logic [31:0] p;
    for (int i = 0; i < 3; i++) begin
      do_mul(0, ta[i], tb[i], 1'b1, acc_ok, lat, p, tmo);
      total++; if (lat != 18 || tmo) begin bad++; $display("FAIL signed_latency[%0d]: got %0d want 18", i, lat); end
      total++; if (p !== te[i]) begin bad++; $display("FAIL signed_prod[%0d]: got %h want %h", i, p, te[i]); end
    end
    do_mul(2, 16'h8000, 16'h8000, 1'b1, acc_ok, lat, p, tmo);
    total++; if (lat != 3 || tmo) begin bad++; $display("FAIL signed_s16_latency: got %0d want 3", lat); end
    total++; if (p !== 32'h4000_0000) begin bad++; $display("FAIL signed_s16_prod: got %h want 40000000", p); end
  endtask

  task automatic test_hold_done();
    logic [31:0] expv;
    int n;
    expv = ref_prod(16'h1234, 16'h00FF, 1'b0);
    @(negedge clk);
    op_a[0] = 16'h1234; op_b[0] = 16'h00FF; op_signed[0] = 1'b0;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      in_valid[0] = 1'b0;
    end while (!out_valid[0] && n < 60);
    total++; if (!out_valid[0]) begin bad++; $display("FAIL hold_timeout: got no out_valid want out_valid"); end
    // offer a new operand set while the result is pending; it must not be taken
    op_a[0] = 16'h0003; op_b[0] = 16'h0005; in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (out_valid[0] !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid[0]); end
      total++; if ({prod_hi[0], prod_lo[0]} !== expv) begin bad++; $display("FAIL hold_prod[%0d]: got %h want %h", i, {prod_hi[0], prod_lo[0]}, expv); end
      total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready[0]); end
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL release_valid: got %b want 0", out_valid[0]); end
    total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready[0]); end
    @(negedge clk);
    in_valid[0] = 1'b0;
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL release_accept: got busy %b want 1", busy[0]); end
    n = 1;
    while (!out_valid[0] && n < 60) begin @(negedge clk); n++; end
    total++; if (n != 17) begin bad++; $display("FAIL release_latency: got %0d want 17", n); end
    total++; if ({prod_hi[0], prod_lo[0]} !== 32'h0000_000F) begin bad++; $display("FAIL release_prod: got %h want 0000000f", {prod_hi[0], prod_lo[0]}); end
    @(negedge clk);
    out_ready[0] = 1'b0;
  endtask

  task automatic test_flush_run();
    bit acc_ok, tmo; int lat; logic [31:0] p;
    @(negedge clk);
    op_a[0] = 16'h1234; op_b[0] = 16'h5678; op_signed[0] = 1'b0;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b0;
    end
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL flush_run_busy_before: got %b want 1", busy[0]); end
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL flush_run_busy_after: got %b want 0", busy[0]); end
    total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL flush_run_valid: got %b want 0", out_valid[0]); end
    total++; if (dbg_state[0] !== IDLE) begin bad++; $display("FAIL flush_run_state: got %0d want IDLE", dbg_state[0]); end
    do_mul(0, 16'h0003, 16'h0005, 1'b0, acc_ok, lat, p, tmo);
    total++; if (acc_ok !== 1'b1) begin bad++; $display("FAIL flush_run_reaccept: got %b want 1", acc_ok); end
    total++; if (lat != 17 || tmo) begin bad++; $display("FAIL flush_run_latency: got %0d want 17", lat); end
    total++; if (p !== 32'h0000_000F) begin bad++; $display("FAIL flush_run_prod: got %h want 0000000f", p); end
  endtask

  task automatic test_flush_idle_done();
    int n;
    @(negedge clk);
    op_a[0] = 16'h0101; op_b[0] = 16'h0002; op_signed[0] = 1'b0;
    in_valid[0] = 1'b1; flush[0] = 1'b1; out_ready[0] = 1'b0;
    #1;
    total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL flush_idle_ready: got %b want 0", in_ready[0]); end
    @(negedge clk);
    total++; if (busy[0] !== 1'b0 || dbg_state[0] !== IDLE) begin bad++; $display("FAIL flush_idle_accept: got busy %b want 0", busy[0]); end
    flush[0] = 1'b0;
    op_a[0] = 16'h0002; op_b[0] = 16'h0003;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      in_valid[0] = 1'b0;
    end while (!out_valid[0] && n < 60);
    total++; if ({prod_hi[0], prod_lo[0]} !== 32'h0000_0006) begin bad++; $display("FAIL flush_done_prod: got %h want 00000006", {prod_hi[0], prod_lo[0]}); end
    out_ready[0] = 1'b1; flush[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0; flush[0] = 1'b0;
    total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL flush_done_valid: got %b want 0", out_valid[0]); end
    total++; if (dbg_state[0] !== IDLE) begin bad++; $display("FAIL flush_done_state: got %0d want IDLE", dbg_state[0]); end
    #1;
    total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL flush_done_ready: got %b want 1", in_ready[0]); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    op_a[0] = 16'hFFFF; op_b[0] = 16'hFFFF; op_signed[0] = 1'b0;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b0;
    end
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before: got %b want 1", busy[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy[0]); end
    total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready[0]); end
    total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid[0]); end
    total++; if ({prod_hi[0], prod_lo[0]} !== 32'h0) begin bad++; $display("FAIL rst_mid_prod: got %h want 0", {prod_hi[0], prod_lo[0]}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL rst_mid_no_completion[%0d]: got %b want 0", i, out_valid[0]); end
    end
  endtask

  task automatic test_back_to_back();
    bit acc_ok, tmo; int lat; logic [31:0] p, e;
    logic [15:0] a, b; logic s;
    for (int i = 0; i < 20; i++) begin
      a = pick_operand(); b = pick_operand(); s = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_prod(a, b, s));
      do_mul(1, a, b, s, acc_ok, lat, p, tmo);
      e = exp_q.pop_front();
      total++; if (!acc_ok || tmo || lat != ref_lat(1, s)) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, ref_lat(1, s)); end
      total++; if (p !== e) begin bad++; $display("FAIL b2b_prod[%0d]: got %h want %h (a=%h b=%h s=%b)", i, p, e, a, b, s); end
    end
  endtask

  // All three instances get the same operands each vector and finish independently.
  task automatic test_random_sweep();
    logic [15:0] a, b; logic s;
    logic [31:0] e;
    logic [NDUT-1:0] done;
    int cyc;
    for (int v = 0; v < 2000; v++) begin
      a = pick_operand(); b = pick_operand(); s = 1'($urandom_range(0, 1));
      e = ref_prod(a, b, s);
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        op_a[k] = a; op_b[k] = b; op_signed[k] = s;
        in_valid[k] = 1'b1; out_ready[k] = 1'b1;
      end
      #1;
      total++; if (in_ready !== {NDUT{1'b1}}) begin bad++; $display("FAIL sweep_accept[%0d]: got %b want 111", v, in_ready); end
      done = '0;
      cyc = 0;
      while (done != {NDUT{1'b1}} && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) in_valid = '0;
        for (int k = 0; k < NDUT; k++) begin
          if (!done[k] && out_valid[k]) begin
            done[k] = 1'b1;
            total++; if (cyc != ref_lat(k, s)) begin bad++; $display("FAIL sweep_latency[%0d] step %0d: got %0d want %0d", v, step_of(k), cyc, ref_lat(k, s)); end
            total++; if ({prod_hi[k], prod_lo[k]} !== e) begin bad++; $display("FAIL sweep_prod[%0d] step %0d: got %h want %h (a=%h b=%h s=%b)", v, step_of(k), {prod_hi[k], prod_lo[k]}, e, a, b, s); end
          end
        end
      end
      total++; if (done != {NDUT{1'b1}}) begin bad++; $display("FAIL sweep_timeout[%0d]: got done %b want 111", v, done); end
    end
    @(negedge clk);
    out_ready = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_unsigned_max();
    test_signed();
    test_hold_done();
    test_flush_run();
    test_flush_idle_done();
    test_reset_mid_run();
    test_back_to_back();
    test_random_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
